// File: rtl/nibble_compare_seq.sv
// rtl/nibble_compare_seq.sv - multi-cycle XLEN-bit magnitude comparator, one nibble per cycle
//
// Purpose: Compares A and B (signed or unsigned) one 4-bit nibble at a time,
//          MSB nibble first, using a single nibble comparator slice.
//          Configuration macro: EARLY_EXIT_EN
//            defined   - RUN stops at the first unequal nibble
//            undefined - RUN always walks all nibbles (constant time)
// Ports:
//   clk_i         in   1     clock, rising edge
//   rst_ni        in   1     asynchronous reset, active-low
//   req_valid_i   in   1     request valid
//   req_ready_o   out  1     request ready (IDLE only)
//   a_i, b_i      in   XLEN  operands
//   signed_i      in   1     1: two's-complement compare, 0: unsigned
//   resp_valid_o  out  1     result valid (DONE)
//   resp_ready_i  in   1     result consumed
//   lt_o/gt_o/eq_o out 1     one-hot result while resp_valid_o=1

module nibble_cmp_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lt,
    output logic       gt,
    output logic       eq
);
    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);
endmodule

module nibble_compare_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            signed_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic            lt_o,
    output logic            gt_o,
    output logic            eq_o
);
    localparam int NIBBLES = XLEN / 4;
    localparam int IDXW    = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              signed_q;
    logic [IDXW-1:0]   idx;
    logic              sticky_hit;
    logic              sticky_lt;
    logic              sticky_gt;

    logic [3:0]        nib_a_raw;
    logic [3:0]        nib_b_raw;
    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic              is_top;
    logic              bias;
    logic              s_lt;
    logic              s_gt;
    logic              s_eq;
    logic              res_lt;
    logic              res_gt;
    logic              run_done;

    assign nib_a_raw = a_q[{idx, 2'b00} +: 4];
    assign nib_b_raw = b_q[{idx, 2'b00} +: 4];
    assign is_top    = (idx == IDXW'(NIBBLES - 1));

    // Flipping the sign bit of the top nibble maps two's-complement order
    // onto unsigned order, so the same slice serves both compare modes.
    assign bias  = signed_q & is_top;
    assign nib_a = {nib_a_raw[3] ^ bias, nib_a_raw[2:0]};
    assign nib_b = {nib_b_raw[3] ^ bias, nib_b_raw[2:0]};

    nibble_cmp_slice compare_ins (
        .a  (nib_a),
        .b  (nib_b),
        .lt (s_lt),
        .gt (s_gt),
        .eq (s_eq)
    );

    // The first unequal nibble decides; later nibbles only matter while
    // everything above them has compared equal.
    assign res_lt = sticky_hit ? sticky_lt : s_lt;
    assign res_gt = sticky_hit ? sticky_gt : s_gt;

`ifdef EARLY_EXIT_EN
    assign run_done = !s_eq || (idx == '0);
`else
    assign run_done = (idx == '0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            signed_q     <= 1'b0;
            idx          <= '0;
            sticky_hit   <= 1'b0;
            sticky_lt    <= 1'b0;
            sticky_gt    <= 1'b0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            lt_o         <= 1'b0;
            gt_o         <= 1'b0;
            eq_o         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        a_q         <= a_i;
                        b_q         <= b_i;
                        signed_q    <= signed_i;
                        idx         <= IDXW'(NIBBLES - 1);
                        sticky_hit  <= 1'b0;
                        sticky_lt   <= 1'b0;
                        sticky_gt   <= 1'b0;
                        req_ready_o <= 1'b0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!sticky_hit && !s_eq) begin
                        sticky_hit <= 1'b1;
                        sticky_lt  <= s_lt;
                        sticky_gt  <= s_gt;
                    end
                    if (run_done) begin
                        resp_valid_o <= 1'b1;
                        lt_o         <= res_lt;
                        gt_o         <= res_gt;
                        eq_o         <= !res_lt && !res_gt;
                        state        <= S_DONE;
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        lt_o         <= 1'b0;
                        gt_o         <= 1'b0;
                        eq_o         <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    lt_o         <= 1'b0;
                    gt_o         <= 1'b0;
                    eq_o         <= 1'b0;
                end
            endcase
        end
    end
endmodule
